// File: rtl/i2s_rx.sv
// Philips I2S receiver: synchronizes the external bit clock, word select and data,
// assembles left/right words and presents them as a valid/ready sample pair.
module i2s_rx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              enable,
    input  logic              tclk,
    input  logic              ws,
    input  logic              td,
    output logic [DATA_W-1:0] data_left,
    output logic [DATA_W-1:0] data_right,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One shared chain keeps tclk, ws and td aligned: {td, ws, tclk} per stage, index 0 newest.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        tclk_prev_q;
    logic                        last_ws_q;
    state_t                      state_q, state_d;
    logic [DATA_W-1:0]           word_q, word_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]           left_hold_q, left_hold_d;
    logic                        left_done_q, left_done_d;
    logic [DATA_W-1:0]           data_left_q, data_left_d;
    logic [DATA_W-1:0]           data_right_q, data_right_d;
    logic                        data_valid_q, data_valid_d;
    logic                        overrun_q, overrun_d;

    logic              tclk_s, ws_s, td_s;
    logic              bit_event, ws_change, pair_done, transfer;
    logic [DATA_W-1:0] word_with_bit;

    assign tclk_s    = sync_q[SYNC_STAGES-1][0];
    assign ws_s      = sync_q[SYNC_STAGES-1][1];
    assign td_s      = sync_q[SYNC_STAGES-1][2];
    assign bit_event = tclk_s & ~tclk_prev_q;
    assign ws_change = bit_event & (ws_s != last_ws_q);
    assign transfer  = data_valid_q & data_ready;

    // Word with the current bit dropped into place; once bit_cnt saturates nothing matches.
    always_comb begin
        word_with_bit = word_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(DATA_W - 1 - i)) begin
                word_with_bit[i] = td_s;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        left_hold_d = left_hold_q;
        left_done_d = left_done_q;
        pair_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (ws_change) begin
                    state_d   = RUN;
                    word_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            RUN: begin
                if (ws_change) begin
                    word_d    = '0;
                    bit_cnt_d = '0;
                    if (!last_ws_q) begin
                        left_hold_d = word_with_bit;
                        left_done_d = 1'b1;
                    end else if (left_done_q) begin
                        pair_done   = 1'b1;
                        left_done_d = 1'b0;
                    end
                end else if (bit_event) begin
                    word_d = word_with_bit;
                    if (bit_cnt_q != CNT_W'(DATA_W)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d     = IDLE;
            word_d      = '0;
            bit_cnt_d   = '0;
            left_done_d = 1'b0;
            pair_done   = 1'b0;
        end
    end

    // A completing right word goes straight to the outputs alongside the held left word.
    always_comb begin
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        data_valid_d = data_valid_q & ~transfer;
        overrun_d    = overrun_q & ~overrun_clr;
        if (pair_done) begin
            if (!data_valid_q || transfer) begin
                data_left_d  = left_hold_q;
                data_right_d = word_with_bit;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (!enable) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q       <= '0;
            tclk_prev_q  <= 1'b0;
            last_ws_q    <= 1'b0;
            state_q      <= IDLE;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            left_hold_q  <= '0;
            left_done_q  <= 1'b0;
            data_left_q  <= '0;
            data_right_q <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], {td, ws, tclk}};
            tclk_prev_q  <= tclk_s;
            if (bit_event) begin
                last_ws_q <= ws_s;
            end
            state_q      <= state_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            left_hold_q  <= left_hold_d;
            left_done_q  <= left_done_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_left  = data_left_q;
    assign data_right = data_right_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips I2S frames at i_clk/8 and checks pairs,
// handshake, overrun, word-length handling, enable drop and mid-frame reset.
module tb_i2s_rx;

    localparam int DW = 32;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          tclk = 1'b0;
    logic          ws = 1'b0;
    logic          td = 1'b0;
    logic          data_ready = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [DW-1:0] data_left, data_right;
    logic          data_valid, overrun;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic cur_ws = 1'b0;
    logic pending_lsb = 1'b0;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .enable     (enable),
        .tclk       (tclk),
        .ws         (ws),
        .td         (td),
        .data_left  (data_left),
        .data_right (data_right),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bit event: pulse 1 raises data_ready, pulse 2 raises overrun_clr, exactly in
    // the cycle the receiver acts on this event.
    task automatic send_event(input logic w, input logic d, input int pulse);
        @(negedge clk);
        tclk = 1'b0; ws = w; td = d;
        repeat (3) @(negedge clk);
        tclk = 1'b1;
        repeat (SS) @(posedge clk);
        @(negedge clk);
        if (pulse == 1) begin
            vec_cnt++;
            if (data_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL simul_old_held: data_valid=%b expected 1", data_valid);
            end
            data_ready = 1'b1;
        end
        if (pulse == 2) overrun_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0; overrun_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic ch, input logic [63:0] w, input int n);
        if (cur_ws != ch) send_event(ch, pending_lsb, 0);
        for (int i = n - 1; i >= 1; i--) send_event(ch, w[i], 0);
        pending_lsb = w[0];
        cur_ws = ch;
    endtask

    task automatic send_tail(input int pulse);
        send_event(1'b0, pending_lsb, pulse);
        cur_ws = 1'b0;
    endtask

    task automatic do_transfer(input string tag);
        @(negedge clk); data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); data_ready = 1'b0;
        vec_cnt++;
        if (data_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_valid_clear: data_valid=%b expected 0", tag, data_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++; if (data_left !== '0) begin err_cnt++; $display("FAIL reset_left: got %h expected 0", data_left); end
        vec_cnt++; if (data_right !== '0) begin err_cnt++; $display("FAIL reset_right: got %h expected 0", data_right); end
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_basic();
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        send_word(1'b0, 64'hA5A5_0001, 32);
        send_word(1'b1, 64'h5A5A_0002, 32);
        send_word(1'b0, 64'hA5A5_0001, 32);
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_first_discard: data_valid=%b expected 0", data_valid); end
        send_word(1'b1, 64'h5A5A_0002, 32);
        send_tail(0);
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
        vec_cnt++; if (data_left !== 32'hA5A5_0001) begin err_cnt++; $display("FAIL basic_left: got %h expected a5a50001", data_left); end
        vec_cnt++; if (data_right !== 32'h5A5A_0002) begin err_cnt++; $display("FAIL basic_right: got %h expected 5a5a0002", data_right); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        do_transfer("basic");
        $display("test_basic: pair a5a50001/5a5a0002 transferred");
    endtask

    task automatic test_backpressure();
        send_word(1'b0, 64'h1111_1111, 32);
        send_word(1'b1, 64'h2222_2222, 32);
        send_tail(0);
        vec_cnt++; if (data_left !== 32'h1111_1111) begin err_cnt++; $display("FAIL bp_first_left: got %h expected 11111111", data_left); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_no_overrun_yet: got %b expected 0", overrun); end
        send_word(1'b0, 64'h3333_3333, 32);
        send_word(1'b1, 64'h4444_4444, 32);
        send_tail(2);
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid_held: got %b expected 1", data_valid); end
        vec_cnt++; if (data_left !== 32'h1111_1111) begin err_cnt++; $display("FAIL bp_left_held: got %h expected 11111111", data_left); end
        vec_cnt++; if (data_right !== 32'h2222_2222) begin err_cnt++; $display("FAIL bp_right_held: got %h expected 22222222", data_right); end
        vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL bp_overrun_set_wins: got %b expected 1", overrun); end
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_overrun_clr: got %b expected 0", overrun); end
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid_after_clr: got %b expected 1", data_valid); end
        $display("test_backpressure: held 11111111/22222222, dropped second pair");
    endtask

    task automatic test_back_to_back();
        send_word(1'b0, 64'h0F0F_1234, 32);
        send_word(1'b1, 64'hF0F0_5678, 32);
        send_tail(1);
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid: got %b expected 1", data_valid); end
        vec_cnt++; if (data_left !== 32'h0F0F_1234) begin err_cnt++; $display("FAIL b2b_left: got %h expected 0f0f1234", data_left); end
        vec_cnt++; if (data_right !== 32'hF0F0_5678) begin err_cnt++; $display("FAIL b2b_right: got %h expected f0f05678", data_right); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        do_transfer("b2b");
        $display("test_back_to_back: old pair transferred, new pair 0f0f1234/f0f05678 loaded");
    endtask

    task automatic test_word_length();
        send_word(1'b0, 64'hAB_CDEF, 24);
        send_word(1'b1, 64'h12_3456, 24);
        send_tail(0);
        vec_cnt++; if (data_left !== 32'hABCD_EF00) begin err_cnt++; $display("FAIL len24_left: got %h expected abcdef00", data_left); end
        vec_cnt++; if (data_right !== 32'h1234_5600) begin err_cnt++; $display("FAIL len24_right: got %h expected 12345600", data_right); end
        do_transfer("len24");
        send_word(1'b0, 64'h12_3456_789A, 40);
        send_word(1'b1, 64'hFE_DCBA_9876, 40);
        send_tail(0);
        vec_cnt++; if (data_left !== 32'h1234_5678) begin err_cnt++; $display("FAIL len40_left: got %h expected 12345678", data_left); end
        vec_cnt++; if (data_right !== 32'hFEDC_BA98) begin err_cnt++; $display("FAIL len40_right: got %h expected fedcba98", data_right); end
        do_transfer("len40");
        $display("test_word_length: 24-bit padded, 40-bit truncated");
    endtask

    task automatic test_disable();
        logic [63:0] w;
        send_word(1'b0, 64'hCAFE_0001, 32);
        send_word(1'b1, 64'hCAFE_0002, 32);
        send_tail(0);
        send_word(1'b0, 64'hDEAD_0003, 32);
        w = 64'hDEAD_0004;
        send_event(1'b1, pending_lsb, 0);
        for (int i = 31; i >= 16; i--) send_event(1'b1, w[i], 0);
        @(negedge clk); enable = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL dis_valid: got %b expected 0", data_valid); end
        vec_cnt++; if (data_left !== 32'hCAFE_0001) begin err_cnt++; $display("FAIL dis_left_hold: got %h expected cafe0001", data_left); end
        vec_cnt++; if (data_right !== 32'hCAFE_0002) begin err_cnt++; $display("FAIL dis_right_hold: got %h expected cafe0002", data_right); end
        for (int i = 15; i >= 1; i--) send_event(1'b1, w[i], 0);
        pending_lsb = w[0];
        cur_ws = 1'b1;
        send_tail(0);
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL dis_no_pair: got %b expected 0", data_valid); end
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        send_word(1'b0, 64'h0123_4567, 32);
        send_word(1'b1, 64'h89AB_CDEF, 32);
        send_word(1'b0, 64'h1357_9BDF, 32);
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL resync_discard: data_valid=%b expected 0", data_valid); end
        send_word(1'b1, 64'h2468_ACE0, 32);
        send_tail(0);
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL resync_valid: got %b expected 1", data_valid); end
        vec_cnt++; if (data_left !== 32'h1357_9BDF) begin err_cnt++; $display("FAIL resync_left: got %h expected 13579bdf", data_left); end
        vec_cnt++; if (data_right !== 32'h2468_ACE0) begin err_cnt++; $display("FAIL resync_right: got %h expected 2468ace0", data_right); end
        $display("test_disable: enable drop discarded partial pair, resync from second frame");
    endtask

    task automatic test_reset_midframe();
        send_word(1'b0, 64'h7777_7777, 32);
        send_word(1'b1, 64'h8888_8888, 32);
        send_tail(0);
        vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_overrun: got %b expected 1", overrun); end
        for (int i = 0; i < 5; i++) send_event(1'b0, 1'b1, 0);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        vec_cnt++; if (data_left !== '0) begin err_cnt++; $display("FAIL rst_mid_left: got %h expected 0", data_left); end
        vec_cnt++; if (data_right !== '0) begin err_cnt++; $display("FAIL rst_mid_right: got %h expected 0", data_right); end
        vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_valid: got %b expected 0", data_valid); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
        tclk = 1'b0; ws = 1'b0; td = 1'b0;
        cur_ws = 1'b0; pending_lsb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_word(1'b0, 64'h0BAD_F00D, 32);
        send_word(1'b1, 64'h600D_CAFE, 32);
        send_word(1'b0, 64'h7654_3210, 32);
        send_word(1'b1, 64'hFEDC_BA90, 32);
        send_tail(0);
        vec_cnt++; if (data_left !== 32'h7654_3210) begin err_cnt++; $display("FAIL rst_recover_left: got %h expected 76543210", data_left); end
        vec_cnt++; if (data_right !== 32'hFEDC_BA90) begin err_cnt++; $display("FAIL rst_recover_right: got %h expected fedcba90", data_right); end
        $display("test_reset_midframe: outputs zeroed, recovery pair 76543210/fedcba90");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_word_length();
        test_disable();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
